// File: rtl/bus_pkg.sv
// Shared definitions for the CPU data-bus demultiplexer: FSM encoding and
// default address map / timeout values.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [31:0] MMIO_BASE_DEF = 32'hFFFF_0000;
    localparam int          TIMEOUT_DEF   = 15;

endpackage

// File: rtl/multiplexer_2to1.sv
// Generic two-input multiplexer shared with the processor datapath.
module multiplexer_2to1 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sel_i,
    output logic [WIDTH-1:0] y_o
);

    assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/data_bus_demux.sv
// Routes the CPU data-memory port to data memory (target 0) or MMIO (target 1)
// using a registered four-phase req/ack handshake with a per-transaction timeout.
module data_bus_demux
    import bus_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] MMIO_BASE  = ADDR_WIDTH'(MMIO_BASE_DEF),
    parameter int                    TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_ack,
    output logic                  cpu_err,
    output logic                  t0_req,
    output logic                  t0_we,
    output logic [ADDR_WIDTH-1:0] t0_addr,
    output logic [DATA_WIDTH-1:0] t0_wdata,
    input  logic [DATA_WIDTH-1:0] t0_rdata,
    input  logic                  t0_ack,
    output logic                  t1_req,
    output logic                  t1_we,
    output logic [ADDR_WIDTH-1:0] t1_addr,
    output logic [DATA_WIDTH-1:0] t1_wdata,
    input  logic [DATA_WIDTH-1:0] t1_rdata,
    input  logic                  t1_ack
);

    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_e                  state_q;
    logic                    sel_q;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    ack_q;
    logic                    err_q;
    logic [CW-1:0]           cnt_q;

    logic                    addr_hit;
    logic                    tgt_ack;
    logic [DATA_WIDTH-1:0]   tgt_rdata;

    assign addr_hit = (cpu_addr >= MMIO_BASE);
    // Only the captured target's ack counts; the other target is ignored.
    assign tgt_ack  = sel_q ? t1_ack : t0_ack;

    multiplexer_2to1 #(
        .WIDTH(DATA_WIDTH)
    ) u_rdata_mux (
        .a_i  (t0_rdata),
        .b_i  (t1_rdata),
        .sel_i(sel_q),
        .y_o  (tgt_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cpu_req) begin
                        sel_q   <= addr_hit;
                        we_q    <= cpu_we;
                        addr_q  <= cpu_addr;
                        wdata_q <= cpu_wdata;
                        cnt_q   <= '0;
                        state_q <= addr_hit ? BUSY1 : BUSY0;
                    end
                end
                BUSY0, BUSY1: begin
                    // Ack beats a timeout landing on the same edge.
                    if (tgt_ack) begin
                        rdata_q <= we_q ? '0 : tgt_rdata;
                        err_q   <= 1'b0;
                        ack_q   <= 1'b1;
                        state_q <= DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        ack_q   <= 1'b1;
                        state_q <= DONE;
                    end
                    if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    if (!cpu_req) begin
                        ack_q   <= 1'b0;
                        err_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign t0_req    = (state_q == BUSY0);
    assign t1_req    = (state_q == BUSY1);
    assign t0_we     = we_q;
    assign t1_we     = we_q;
    assign t0_addr   = addr_q;
    assign t1_addr   = addr_q;
    assign t0_wdata  = wdata_q;
    assign t1_wdata  = wdata_q;
    assign cpu_rdata = rdata_q;
    assign cpu_ack   = ack_q;
    assign cpu_err   = err_q;

endmodule
